// File: rtl/flow_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// flow_ctrl_fsm
//
// Flow-control state machine for a multi-FIFO datapath. It watches
// NUM_FIFOS occupancy counters and empty flags. During INIT it latches the
// almost-empty/almost-full thresholds and validates them. It then tracks
// IDLE/ACTIVE with a debounced return to IDLE, and produces per-FIFO
// almost-empty/almost-full flags plus a pause back-pressure request. Bad
// thresholds or an occupancy above DEPTH park the machine in a sticky ERROR
// state, which only init (or rst) leaves.
//
// Ports
//   clk                   : single clock, rising edge
//   rst                   : asynchronous active-high reset
//   init                  : request (re)initialisation / threshold load
//   umbral_entrada_empty  : almost-empty threshold candidate (CNT_W)
//   umbral_entrada_full   : almost-full threshold candidate (CNT_W)
//   fifo_empty            : per-FIFO empty flag (NUM_FIFOS)
//   fifo_count            : packed occupancies, FIFO i at [i*CNT_W +: CNT_W]
//   umbral_empty          : active almost-empty threshold (registered)
//   umbral_full           : active almost-full threshold (registered)
//   estado                : current state, one-hot (registered)
//   estado_proximo        : next state (combinational)
//   idle                  : estado == IDLE
//   error                 : estado == ERROR
//   almost_empty          : per-FIFO count <= umbral_empty (registered)
//   almost_full           : per-FIFO count >= umbral_full (registered)
//   pause                 : back-pressure request, ACTIVE only (registered)
// ---------------------------------------------------------------------------
module flow_ctrl_fsm #(
  parameter int NUM_FIFOS = 4,
  parameter int CNT_W     = 5,
  parameter int DEPTH     = 16,
  parameter int IDLE_HOLD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic [CNT_W-1:0]           umbral_entrada_empty,
  input  logic [CNT_W-1:0]           umbral_entrada_full,
  input  logic [NUM_FIFOS-1:0]       fifo_empty,
  input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
  output logic [CNT_W-1:0]           umbral_empty,
  output logic [CNT_W-1:0]           umbral_full,
  output logic [4:0]                 estado,
  output logic [4:0]                 estado_proximo,
  output logic                       idle,
  output logic                       error,
  output logic [NUM_FIFOS-1:0]       almost_empty,
  output logic [NUM_FIFOS-1:0]       almost_full,
  output logic                       pause
);

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_e;

  localparam int HOLD_W = $clog2(IDLE_HOLD + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  HALF_C   = CNT_W'(DEPTH / 2);
  localparam logic [HOLD_W-1:0] HOLD_C   = HOLD_W'(IDLE_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  // State and datapath registers with their next-state values.
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       ue_q, ue_d;
  logic [CNT_W-1:0]       uf_q, uf_d;
  logic [NUM_FIFOS-1:0]   ae_q, ae_d;
  logic [NUM_FIFOS-1:0]   af_q, af_d;
  logic                   pause_q, pause_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;

  // Decoded conditions shared by the next-state and datapath logic.
  logic                   all_empty_s;
  logic                   thr_bad_s;
  logic                   ovf_s;
  logic                   hold_done_s;
  logic [CNT_W-1:0]       count_s [NUM_FIFOS];

  // Unpack the occupancy bus into one count per FIFO.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      count_s[i] = fifo_count[i*CNT_W +: CNT_W];
    end
  end

  // Input qualifiers: all-empty, threshold validity, occupancy overflow.
  always_comb begin
    all_empty_s = &fifo_empty;
    // Thresholds must leave a non-empty band between them and the full
    // threshold must be reachable by a FIFO of DEPTH entries.
    thr_bad_s   = (umbral_entrada_empty >= umbral_entrada_full) ||
                  (umbral_entrada_full > DEPTH_C);
    ovf_s       = 1'b0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (count_s[i] > DEPTH_C) begin
        ovf_s = 1'b1;
      end else begin
        ovf_s = ovf_s;
      end
    end
    // hold_q counts the earlier consecutive all-empty ACTIVE cycles, so the
    // current all-empty cycle completes the run when hold_q reaches
    // IDLE_HOLD-1.
    hold_done_s = all_empty_s && (hold_q >= (HOLD_C - HOLD_ONE));
  end

  // Next-state logic; priority inside each state is top-down.
  always_comb begin
    state_d = ST_RESET;
    case (state_q)
      ST_RESET: begin
        if (init) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_RESET;
        end
      end
      ST_INIT: begin
        if (thr_bad_s) begin
          state_d = ST_ERROR;
        end else if (!init && all_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (ovf_s) begin
          state_d = ST_ERROR;
        end else if (!all_empty_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (ovf_s) begin
          state_d = ST_ERROR;
        end else if (hold_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        // Sticky: only a fresh initialisation leaves ERROR.
        if (init) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        // Any non-legal one-hot pattern recovers through RESET.
        state_d = ST_RESET;
      end
    endcase
  end

  // Threshold load and idle-hold counter next values.
  always_comb begin
    ue_d   = ue_q;
    uf_d   = uf_q;
    hold_d = '0;
    // Every valid INIT cycle reloads, so the last value before leaving wins;
    // an invalid cycle keeps the previously accepted pair.
    if ((state_q == ST_INIT) && !thr_bad_s) begin
      ue_d = umbral_entrada_empty;
      uf_d = umbral_entrada_full;
    end else begin
      ue_d = ue_q;
      uf_d = uf_q;
    end
    if ((state_q == ST_ACTIVE) && all_empty_s) begin
      // Saturate so the counter can never wrap back to a short run.
      if (hold_q != HOLD_C) begin
        hold_d = hold_q + HOLD_ONE;
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d = '0;
    end
  end

  // Per-FIFO flags and pause, computed against the registered thresholds.
  always_comb begin
    ae_d    = '0;
    af_d    = '0;
    pause_d = 1'b0;
    if ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        ae_d[i] = (count_s[i] <= ue_q);
        af_d[i] = (count_s[i] >= uf_q);
      end
      // Back-pressure is only meaningful while data is moving.
      pause_d = (state_q == ST_ACTIVE) && (|af_d);
    end else begin
      ae_d    = '0;
      af_d    = '0;
      pause_d = 1'b0;
    end
  end

  // State, threshold, flag and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      ue_q    <= '0;
      uf_q    <= HALF_C;
      ae_q    <= '0;
      af_q    <= '0;
      pause_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ue_q    <= ue_d;
      uf_q    <= uf_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      pause_q <= pause_d;
      hold_q  <= hold_d;
    end
  end

  // Output mapping; idle/error are Moore decodes of the state register.
  always_comb begin
    estado         = state_q;
    estado_proximo = state_d;
    idle           = (state_q == ST_IDLE);
    error          = (state_q == ST_ERROR);
    umbral_empty   = ue_q;
    umbral_full    = uf_q;
    almost_empty   = ae_q;
    almost_full    = af_q;
    pause          = pause_q;
  end

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
module tb_flow_ctrl_fsm;

  localparam int NF   = 4;
  localparam int CW   = 5;
  localparam int DEP  = 16;
  localparam int HOLD = 2;

  localparam int S_RST  = 0;
  localparam int S_INIT = 1;
  localparam int S_IDLE = 2;
  localparam int S_ACT  = 3;
  localparam int S_ERR  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            init;
  logic [CW-1:0]   ue_in, uf_in;
  logic [NF-1:0]   fe;
  logic [CW-1:0]   cnt [NF];
  logic [NF*CW-1:0] fcount;

  logic [CW-1:0]   umbral_empty, umbral_full;
  logic [4:0]      estado, estado_proximo;
  logic            idle, error, pause;
  logic [NF-1:0]   almost_empty, almost_full;

  int errors = 0;
  int checks = 0;

  // Reference model: state index, thresholds, flags, all-empty run length.
  int            m_st;
  int            m_ue, m_uf;
  int            m_run;
  logic [NF-1:0] m_ae, m_af;
  logic          m_pause;

  always #5 clk = ~clk;

  always_comb begin
    fcount = '0;
    for (int i = 0; i < NF; i++) fcount[i*CW +: CW] = cnt[i];
  end

  flow_ctrl_fsm #(.NUM_FIFOS(NF), .CNT_W(CW), .DEPTH(DEP), .IDLE_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .init(init),
    .umbral_entrada_empty(ue_in), .umbral_entrada_full(uf_in),
    .fifo_empty(fe), .fifo_count(fcount),
    .umbral_empty(umbral_empty), .umbral_full(umbral_full),
    .estado(estado), .estado_proximo(estado_proximo),
    .idle(idle), .error(error),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .pause(pause)
  );

  function automatic logic [4:0] onehot(input int s);
    logic [4:0] v;
    v = 5'b00001;
    return v << s;
  endfunction

  task automatic model_reset();
    m_st = S_RST; m_ue = 0; m_uf = DEP / 2; m_run = 0;
    m_ae = '0; m_af = '0; m_pause = 1'b0;
  endtask

  // Next state from the rules, using the current inputs.
  function automatic int m_next();
    bit all_e, bad, ovf;
    all_e = (fe == {NF{1'b1}});
    bad   = (int'(ue_in) >= int'(uf_in)) || (int'(uf_in) > DEP);
    ovf   = 1'b0;
    for (int i = 0; i < NF; i++) if (int'(cnt[i]) > DEP) ovf = 1'b1;
    case (m_st)
      S_RST:  return init ? S_INIT : S_RST;
      S_INIT: begin
        if (bad) return S_ERR;
        if (!init && all_e) return S_IDLE;
        return S_INIT;
      end
      S_IDLE: begin
        if (init) return S_INIT;
        if (ovf) return S_ERR;
        if (!all_e) return S_ACT;
        return S_IDLE;
      end
      S_ACT: begin
        if (init) return S_INIT;
        if (ovf) return S_ERR;
        if (all_e && (m_run + 1 >= HOLD)) return S_IDLE;
        return S_ACT;
      end
      S_ERR:  return init ? S_INIT : S_ERR;
      default: return S_RST;
    endcase
  endfunction

  // Advance model and DUT by one clock edge (no checking here).
  task automatic step();
    int            nst, nue, nuf, nrun;
    logic [NF-1:0] nae, naf;
    logic          np;
    bit            all_e, bad;
    all_e = (fe == {NF{1'b1}});
    bad   = (int'(ue_in) >= int'(uf_in)) || (int'(uf_in) > DEP);
    nst   = m_next();
    nae = '0; naf = '0; np = 1'b0;
    if (m_st == S_IDLE || m_st == S_ACT) begin
      for (int i = 0; i < NF; i++) begin
        nae[i] = (int'(cnt[i]) <= m_ue);
        naf[i] = (int'(cnt[i]) >= m_uf);
      end
      np = (m_st == S_ACT) && (naf != '0);
    end
    nue = m_ue; nuf = m_uf;
    if (m_st == S_INIT && !bad) begin nue = int'(ue_in); nuf = int'(uf_in); end
    nrun = (m_st == S_ACT && all_e) ? m_run + 1 : 0;
    @(posedge clk); #1;
    m_st = nst; m_ue = nue; m_uf = nuf; m_run = nrun;
    m_ae = nae; m_af = naf; m_pause = np;
  endtask

  task automatic set_idle_inputs();
    fe = '1;
    for (int i = 0; i < NF; i++) cnt[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; ue_in = '0; uf_in = '0; set_idle_inputs();
    model_reset();
    @(posedge clk); #1;
    checks++; if (estado !== 5'b00001) begin errors++; $display("FAIL rst_estado: got %b expected %b", estado, 5'b00001); end
    checks++; if (estado_proximo !== 5'b00001) begin errors++; $display("FAIL rst_next: got %b expected %b", estado_proximo, 5'b00001); end
    checks++; if (umbral_empty !== 5'd0 || umbral_full !== 5'd8) begin errors++; $display("FAIL rst_thr: got %0d/%0d expected 0/8", umbral_empty, umbral_full); end
    checks++; if (almost_empty !== 4'b0 || almost_full !== 4'b0 || pause !== 1'b0) begin errors++; $display("FAIL rst_flags: got ae=%b af=%b p=%b expected zeros", almost_empty, almost_full, pause); end
    checks++; if (idle !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_decode: got idle=%b err=%b expected 0/0", idle, error); end
    rst = 1'b0;
  endtask

  task automatic test_init_load();
    ue_in = 5'd3; uf_in = 5'd12; init = 1'b1; #1;
    checks++; if (estado_proximo !== 5'b00010) begin errors++; $display("FAIL init_next: got %b expected %b", estado_proximo, 5'b00010); end
    step();
    checks++; if (estado !== 5'b00010) begin errors++; $display("FAIL init_state: got %b expected %b", estado, 5'b00010); end
    checks++; if (umbral_empty !== 5'd0 || umbral_full !== 5'd8) begin errors++; $display("FAIL init_thr_early: got %0d/%0d expected 0/8", umbral_empty, umbral_full); end
    init = 1'b0; #1;
    checks++; if (estado_proximo !== 5'b00100) begin errors++; $display("FAIL init_next_idle: got %b expected %b", estado_proximo, 5'b00100); end
    step();
    checks++; if (estado !== 5'b00100 || idle !== 1'b1) begin errors++; $display("FAIL init_idle: got %b idle=%b expected 00100 idle=1", estado, idle); end
    checks++; if (umbral_empty !== 5'd3 || umbral_full !== 5'd12) begin errors++; $display("FAIL init_thr: got %0d/%0d expected 3/12", umbral_empty, umbral_full); end
  endtask

  task automatic test_active_flags();
    fe = 4'b1011; cnt[2] = 5'd13;
    step();
    checks++; if (estado !== 5'b01000 || idle !== 1'b0) begin errors++; $display("FAIL act_enter: got %b expected 01000", estado); end
    checks++; if (almost_full !== 4'b0100 || almost_empty !== 4'b1011 || pause !== 1'b0) begin errors++; $display("FAIL act_flags1: got ae=%b af=%b p=%b expected 1011/0100/0", almost_empty, almost_full, pause); end
    step();
    checks++; if (almost_full !== 4'b0100 || pause !== 1'b1) begin errors++; $display("FAIL act_pause: got af=%b p=%b expected 0100/1", almost_full, pause); end
    cnt[2] = 5'd2;
    step();
    checks++; if (almost_empty !== 4'b1111 || almost_full !== 4'b0000 || pause !== 1'b0) begin errors++; $display("FAIL act_low: got ae=%b af=%b p=%b expected 1111/0000/0", almost_empty, almost_full, pause); end
  endtask

  task automatic test_idle_hold();
    set_idle_inputs();
    step();
    checks++; if (estado !== 5'b01000) begin errors++; $display("FAIL hold_one: got %b expected 01000", estado); end
    fe = 4'b1011; cnt[2] = 5'd5;
    step();
    checks++; if (estado !== 5'b01000) begin errors++; $display("FAIL hold_break: got %b expected 01000", estado); end
    set_idle_inputs();
    step();
    checks++; if (estado !== 5'b01000) begin errors++; $display("FAIL hold_first: got %b expected 01000", estado); end
    step();
    checks++; if (estado !== 5'b00100 || idle !== 1'b1) begin errors++; $display("FAIL hold_idle: got %b idle=%b expected 00100/1", estado, idle); end
  endtask

  task automatic test_bad_thresholds();
    init = 1'b1; ue_in = 5'd9; uf_in = 5'd9;
    step();
    checks++; if (estado !== 5'b00010) begin errors++; $display("FAIL bad_init: got %b expected 00010", estado); end
    checks++; if (estado_proximo !== 5'b10000) begin errors++; $display("FAIL bad_next: got %b expected 10000", estado_proximo); end
    step();
    checks++; if (estado !== 5'b10000 || error !== 1'b1) begin errors++; $display("FAIL bad_err: got %b err=%b expected 10000/1", estado, error); end
    checks++; if (umbral_empty !== 5'd3 || umbral_full !== 5'd12) begin errors++; $display("FAIL bad_thr: got %0d/%0d expected 3/12", umbral_empty, umbral_full); end
    init = 1'b0;
    step();
    checks++; if (estado !== 5'b10000) begin errors++; $display("FAIL bad_sticky: got %b expected 10000", estado); end
    init = 1'b1; ue_in = 5'd1; uf_in = 5'd10;
    step();
    checks++; if (estado !== 5'b00010 || umbral_empty !== 5'd3) begin errors++; $display("FAIL bad_reinit: got %b ue=%0d expected 00010 ue=3", estado, umbral_empty); end
    init = 1'b0;
    step();
    checks++; if (estado !== 5'b00100 || umbral_empty !== 5'd1 || umbral_full !== 5'd10) begin errors++; $display("FAIL bad_reload: got %b %0d/%0d expected 00100 1/10", estado, umbral_empty, umbral_full); end
  endtask

  task automatic test_overflow();
    fe = 4'b1110; cnt[0] = 5'd5;
    step();
    cnt[0] = 5'd17;
    step();
    checks++; if (estado !== 5'b10000 || almost_full !== 4'b0001 || pause !== 1'b1) begin errors++; $display("FAIL ovf_enter: got %b af=%b p=%b expected 10000/0001/1", estado, almost_full, pause); end
    step();
    checks++; if (almost_empty !== 4'b0 || almost_full !== 4'b0 || pause !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL ovf_clear: got ae=%b af=%b p=%b err=%b", almost_empty, almost_full, pause, error); end
    set_idle_inputs();
    step();
    checks++; if (estado !== 5'b10000) begin errors++; $display("FAIL ovf_sticky: got %b expected 10000", estado); end
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    checks++; if (estado !== 5'b00100) begin errors++; $display("FAIL ovf_recover: got %b expected 00100", estado); end
  endtask

  task automatic test_async_reset();
    fe = 4'b1110; cnt[0] = 5'd12;
    step();
    step();
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL arst_pre: got p=%b expected 1", pause); end
    #2 rst = 1'b1;
    #1;
    checks++; if (estado !== 5'b00001 || umbral_full !== 5'd8 || umbral_empty !== 5'd0 || pause !== 1'b0 || almost_full !== 4'b0) begin errors++; $display("FAIL arst_now: got %b %0d/%0d p=%b af=%b", estado, umbral_empty, umbral_full, pause, almost_full); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle_inputs();
  endtask

  task automatic test_random();
    int nxt;
    for (int n = 0; n < 600; n++) begin
      init = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) begin
        ue_in = CW'($urandom); uf_in = CW'($urandom);
      end else begin
        ue_in = CW'($urandom_range(0, 8));
        uf_in = CW'($urandom_range(32'(ue_in) + 1, DEP));
      end
      fe = ($urandom_range(0, 2) == 0) ? {NF{1'b1}} : NF'($urandom);
      for (int i = 0; i < NF; i++) begin
        cnt[i] = fe[i] ? CW'(0) : CW'($urandom_range(1, DEP));
        if ($urandom_range(0, 40) == 0) cnt[i] = CW'($urandom_range(DEP + 1, 31));
      end
      #1;
      nxt = m_next();
      checks++; if (estado_proximo !== onehot(nxt)) begin errors++; $display("FAIL rnd_next[%0d]: got %b expected %b", n, estado_proximo, onehot(nxt)); end
      step();
      checks++; if (estado !== onehot(m_st) || idle !== (m_st == S_IDLE) || error !== (m_st == S_ERR)) begin errors++; $display("FAIL rnd_state[%0d]: got %b i=%b e=%b expected %b", n, estado, idle, error, onehot(m_st)); end
      checks++; if (int'(umbral_empty) != m_ue || int'(umbral_full) != m_uf) begin errors++; $display("FAIL rnd_thr[%0d]: got %0d/%0d expected %0d/%0d", n, umbral_empty, umbral_full, m_ue, m_uf); end
      checks++; if (almost_empty !== m_ae || almost_full !== m_af || pause !== m_pause) begin errors++; $display("FAIL rnd_flags[%0d]: got %b/%b/%b expected %b/%b/%b", n, almost_empty, almost_full, pause, m_ae, m_af, m_pause); end
    end
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_active_flags();
    test_idle_hold();
    test_bad_thresholds();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
